// File: rtl/key_loader_pkg.sv
// Shared types and helpers for the key loader: FSM state encoding, checksum width
// and the XOR fold used to verify a received key.
package key_loader_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SHIFT   = 3'd1,
      CHECK   = 3'd2,
      APPLY   = 3'd3,
      LOCKOUT = 3'd4
   } state_t;

   localparam int CKSUM_W   = 8;
   localparam int KEY_W_MAX = 256;

   // Keys narrower than KEY_W_MAX are zero-extended by the caller; zero bytes fold to nothing.
   function automatic logic [CKSUM_W-1:0] xor_fold(input logic [KEY_W_MAX-1:0] key);
      logic [CKSUM_W-1:0] acc;
      acc = '0;
      for (int k = 0; k < KEY_W_MAX / CKSUM_W; k++) begin
         acc = acc ^ key[k*CKSUM_W +: CKSUM_W];
      end
      return acc;
   endfunction

endpackage

// File: rtl/key_loader_if.sv
// Serial key stream between the secure key source (master) and the key loader (slave).
interface key_loader_if;

   // A bit transfers on a rising edge where sdi_valid && sdi_ready; sdi is LSB first.
   // load_start is a one-cycle pulse that (re)starts a frame and wins over a same-cycle bit.
   logic load_start;
   logic sdi;
   logic sdi_valid;
   logic sdi_ready;

   modport master (
      output load_start,
      output sdi,
      output sdi_valid,
      input  sdi_ready
   );

   modport slave (
      input  load_start,
      input  sdi,
      input  sdi_valid,
      output sdi_ready
   );

endinterface

// File: rtl/key_loader_shreg.sv
// Frame assembly register: bit n of the frame lands in data[n]; done flags the final bit.
module key_loader_shreg #(
   parameter int FRAME_W = 40
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               shift_en,
   input  logic               bit_in,
   output logic [FRAME_W-1:0] data,
   output logic               done
);

   localparam int            CW   = $clog2(FRAME_W);
   localparam logic [CW-1:0] LAST = CW'(FRAME_W - 1);

   logic [CW-1:0] cnt;

   assign done = shift_en && (cnt == LAST);

   // clr outranks shift_en so a restart never keeps a bit from the abandoned frame.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         data <= '0;
         cnt  <= '0;
      end else if (shift_en) begin
         data[cnt] <= bit_in;
         if (cnt == LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_loader.sv
// Key loader top: assembles a serial key frame, verifies it, then drives key_out.
// Build option KEY_LOADER_CHECKSUM_EN appends an 8-bit XOR checksum trailer to each frame.
module key_loader
   import key_loader_pkg::*;
#(
   parameter int KEY_W    = 32,
   parameter int MAX_FAIL = 3
) (
   input  logic             clk,
   input  logic             rst,
   key_loader_if.slave      src,
   output logic [KEY_W-1:0] key_out,
   output logic             key_applied,
   output logic             load_err,
   output logic             locked_out,
   output logic             busy,
   output logic [2:0]       state_dbg
);

   localparam logic [2:0] ST_IDLE    = IDLE;
   localparam logic [2:0] ST_SHIFT   = SHIFT;
   localparam logic [2:0] ST_CHECK   = CHECK;
   localparam logic [2:0] ST_APPLY   = APPLY;
   localparam logic [2:0] ST_LOCKOUT = LOCKOUT;

`ifdef KEY_LOADER_CHECKSUM_EN
   localparam int FRAME_W = KEY_W + CKSUM_W;
`else
   localparam int FRAME_W = KEY_W;
`endif

   logic [2:0]         state;
   logic [2:0]         state_nx;
   logic               ready_q;
   logic [FRAME_W-1:0] frame;
   logic               frame_done;
   logic               shift_en;
   logic               clr;
   logic               cksum_ok;
   logic [3:0]         fail_cnt;
   logic               fail_hit;

   assign shift_en  = (state == ST_SHIFT) && src.sdi_valid && !src.load_start;
   assign clr       = src.load_start && (state != ST_LOCKOUT);
   assign fail_hit  = (fail_cnt == 4'(MAX_FAIL - 1));
   assign src.sdi_ready = ready_q;
   assign state_dbg = state;

   key_loader_shreg #(
      .FRAME_W (FRAME_W)
   ) u_shreg (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .shift_en (shift_en),
      .bit_in   (src.sdi),
      .data     (frame),
      .done     (frame_done)
   );

`ifdef KEY_LOADER_CHECKSUM_EN
   assign cksum_ok = (xor_fold(KEY_W_MAX'(frame[KEY_W-1:0])) == frame[FRAME_W-1:KEY_W]);
`else
   assign cksum_ok = 1'b1;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE, ST_APPLY: begin
            if (src.load_start) state_nx = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (src.load_start)  state_nx = ST_SHIFT;
            else if (frame_done) state_nx = ST_CHECK;
         end
         ST_CHECK: begin
            if (src.load_start) state_nx = ST_SHIFT;
            else if (cksum_ok)  state_nx = ST_APPLY;
            else if (fail_hit)  state_nx = ST_LOCKOUT;
            else                state_nx = ST_IDLE;
         end
         ST_LOCKOUT: state_nx = ST_LOCKOUT;
         default:    state_nx = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so each one appears the cycle the state does.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         ready_q     <= 1'b0;
         busy        <= 1'b0;
         key_out     <= '0;
         key_applied <= 1'b0;
         load_err    <= 1'b0;
         locked_out  <= 1'b0;
         fail_cnt    <= '0;
      end else begin
         state   <= state_nx;
         ready_q <= (state_nx == ST_SHIFT);
         busy    <= (state_nx == ST_SHIFT) || (state_nx == ST_CHECK);
         if (clr) begin
            key_out     <= '0;
            key_applied <= 1'b0;
            load_err    <= 1'b0;
         end else if (state == ST_CHECK) begin
            if (cksum_ok) begin
               key_out     <= frame[KEY_W-1:0];
               key_applied <= 1'b1;
               fail_cnt    <= '0;
            end else begin
               load_err <= 1'b1;
               fail_cnt <= fail_cnt + 4'd1;
               if (fail_hit) locked_out <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader; follows the build's KEY_LOADER_CHECKSUM_EN setting.
module tb_key_loader;

   localparam int KEY_W    = 32;
   localparam int MAX_FAIL = 3;
`ifdef KEY_LOADER_CHECKSUM_EN
   localparam int CK_ON = 1;
`else
   localparam int CK_ON = 0;
`endif
   localparam int FRAME_BITS = KEY_W + 8 * CK_ON;
   localparam int WAIT_MAX   = 100;

   logic             clk = 1'b0;
   logic             rst;
   logic [KEY_W-1:0] key_out;
   logic             key_applied;
   logic             load_err;
   logic             locked_out;
   logic             busy;
   logic [2:0]       state_dbg;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: consecutive failures, lockout flag and expected key_out values.
   int               m_fails  = 0;
   bit               m_locked = 1'b0;
   logic [KEY_W-1:0] exp_q[$];

   key_loader_if bus ();

   key_loader #(
      .KEY_W    (KEY_W),
      .MAX_FAIL (MAX_FAIL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .src         (bus),
      .key_out     (key_out),
      .key_applied (key_applied),
      .load_err    (load_err),
      .locked_out  (locked_out),
      .busy        (busy),
      .state_dbg   (state_dbg)
   );

   // Clock / reset
   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] ref_cksum(input logic [31:0] k);
      return k[7:0] ^ k[15:8] ^ k[23:16] ^ k[31:24];
   endfunction

   // Drivers: every task starts and ends 1 time unit after a rising edge.
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_fails  = 0;
      m_locked = 1'b0;
   endtask

   task automatic pulse_load(input bit with_valid);
      bus.load_start = 1'b1;
      bus.sdi_valid  = with_valid;
      bus.sdi        = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      bus.load_start = 1'b0;
      bus.sdi_valid  = 1'b0;
   endtask

   task automatic send_bits(input logic [39:0] bits, input int n, input int gap_max);
      int g;
      for (int i = 0; i < n; i++) begin
         g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
         for (int j = 0; j < g; j++) begin
            bus.sdi_valid = 1'b0;
            bus.sdi       = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         bus.sdi       = bits[i];
         bus.sdi_valid = 1'b1;
         @(posedge clk); #1;
      end
      bus.sdi_valid = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy !== 1'b0 && n < WAIT_MAX) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   function automatic logic [39:0] make_frame(input logic [31:0] key, input logic [7:0] ck);
      return {ck, key};
   endfunction

   // Tests
   task automatic test_reset();
      bus.load_start = 1'b0;
      bus.sdi        = 1'b0;
      bus.sdi_valid  = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (key_out !== '0) begin errors++; $display("FAIL reset_key_out got=%h exp=0", key_out); end
      checks++; if (key_applied !== 1'b0) begin errors++; $display("FAIL reset_key_applied got=%b exp=0", key_applied); end
      checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got=%b exp=0", load_err); end
      checks++; if (locked_out !== 1'b0) begin errors++; $display("FAIL reset_locked_out got=%b exp=0", locked_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (bus.sdi_ready !== 1'b0) begin errors++; $display("FAIL reset_sdi_ready got=%b exp=0", bus.sdi_ready); end
      checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0 (idle)", state_dbg); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_good_load();
      logic [31:0] key;
      int t0, n, lat;
      key = (CK_ON != 0) ? 32'hA5C30F96 : 32'hDEADBEEF;
      pulse_load(1'b0);
      t0 = cyc;
      checks++; if (bus.sdi_ready !== 1'b1) begin errors++; $display("FAIL good_start_ready got=%b exp=1", bus.sdi_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_start_busy got=%b exp=1", busy); end
      send_bits(make_frame(key, 8'hFF), FRAME_BITS, 0);
      checks++; if (bus.sdi_ready !== 1'b0) begin errors++; $display("FAIL good_check_ready got=%b exp=0", bus.sdi_ready); end
      checks++; if (key_applied !== 1'b0 || key_out !== '0) begin errors++; $display("FAIL good_early_key got=%h/%b exp=0/0", key_out, key_applied); end
      n = 0;
      while (key_applied !== 1'b1 && n < WAIT_MAX) begin
         @(posedge clk); #1;
         n++;
      end
      lat = cyc - t0 + 1;
      checks++; if (lat !== FRAME_BITS + 2) begin errors++; $display("FAIL good_latency got=%0d exp=%0d cycles", lat, FRAME_BITS + 2); end
      checks++; if (key_out !== key) begin errors++; $display("FAIL good_key_out got=%h exp=%h", key_out, key); end
      checks++; if (load_err !== 1'b0 || locked_out !== 1'b0) begin errors++; $display("FAIL good_flags got=%b%b exp=00", load_err, locked_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_end got=%b exp=0", busy); end
      m_fails = 0;
   endtask

`ifdef KEY_LOADER_CHECKSUM_EN
   task automatic test_bad_checksum();
      int n;
      pulse_load(1'b0);
      send_bits(make_frame(32'hA5C30F96, 8'hFE), FRAME_BITS, 0);
      wait_idle(n);
      checks++; if (n >= WAIT_MAX) begin errors++; $display("FAIL bad_timeout got=%0d exp<%0d cycles", n, WAIT_MAX); end
      checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL bad_load_err got=%b exp=1", load_err); end
      checks++; if (key_out !== '0 || key_applied !== 1'b0) begin errors++; $display("FAIL bad_key got=%h/%b exp=0/0", key_out, key_applied); end
      checks++; if (bus.sdi_ready !== 1'b0 || locked_out !== 1'b0) begin errors++; $display("FAIL bad_idle got=%b%b exp=00", bus.sdi_ready, locked_out); end
   endtask

   task automatic test_lockout();
      int n;
      logic [31:0] key;
      do_reset();
      for (int i = 0; i < MAX_FAIL; i++) begin
         key = $urandom;
         pulse_load(1'b0);
         checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL lock_err_cleared_%0d got=%b exp=0", i, load_err); end
         send_bits(make_frame(key, ~ref_cksum(key)), FRAME_BITS, 0);
         wait_idle(n);
         m_fails++;
         m_locked = (m_fails >= MAX_FAIL);
         checks++; if (locked_out !== m_locked) begin errors++; $display("FAIL lock_after_%0d got=%b exp=%b", i, locked_out, m_locked); end
      end
      pulse_load(1'b0);
      send_bits(make_frame(32'h1, 8'h1), 4, 0);
      checks++; if (bus.sdi_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL lock_ignore_load got=%b%b exp=00", bus.sdi_ready, busy); end
      checks++; if (key_out !== '0 || locked_out !== 1'b1) begin errors++; $display("FAIL lock_hold got=%h/%b exp=0/1", key_out, locked_out); end
      do_reset();
      checks++; if (locked_out !== 1'b0 || load_err !== 1'b0) begin errors++; $display("FAIL lock_rst_clear got=%b%b exp=00", locked_out, load_err); end
   endtask

   task automatic test_fail_clear();
      int n;
      logic [31:0] key;
      bit good;
      bit pattern[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         good = pattern[i];
         key  = $urandom;
         pulse_load(1'b0);
         send_bits(make_frame(key, good ? ref_cksum(key) : ref_cksum(key) ^ 8'h5A), FRAME_BITS, 1);
         wait_idle(n);
         checks++; if (key_applied !== good || load_err !== !good) begin errors++; $display("FAIL clear_%0d_result got=%b%b exp=%b%b", i, key_applied, load_err, good, !good); end
         checks++; if (locked_out !== 1'b0) begin errors++; $display("FAIL clear_%0d_locked got=%b exp=0", i, locked_out); end
      end
   endtask
`endif

   task automatic test_restart_gaps();
      int n;
      logic [39:0] junk;
      junk = {8'($urandom), 32'($urandom)};
      pulse_load(1'b0);
      send_bits(junk, 17, 2);
      pulse_load(1'b1);
      checks++; if (bus.sdi_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL restart_shift got=%b%b exp=11", bus.sdi_ready, busy); end
      send_bits(make_frame(32'h12345678, 8'h08), FRAME_BITS, 3);
      wait_idle(n);
      checks++; if (n >= WAIT_MAX) begin errors++; $display("FAIL restart_timeout got=%0d exp<%0d cycles", n, WAIT_MAX); end
      checks++; if (key_out !== 32'h12345678 || key_applied !== 1'b1) begin errors++; $display("FAIL restart_key got=%h/%b exp=12345678/1", key_out, key_applied); end
      checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL restart_err got=%b exp=0", load_err); end
      m_fails = 0;
   endtask

   task automatic test_rst_mid_shift();
      int n;
      logic [31:0] key;
      do_reset();
      checks++; if (key_out !== '0 || key_applied !== 1'b0) begin errors++; $display("FAIL rst_apply_clear got=%h/%b exp=0/0", key_out, key_applied); end
      pulse_load(1'b0);
      send_bits({8'($urandom), 32'($urandom)}, 10, 0);
      bus.sdi_valid = 1'b1;
      do_reset();
      bus.sdi_valid = 1'b0;
      checks++; if (bus.sdi_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got=%b%b exp=00", bus.sdi_ready, busy); end
      checks++; if (key_out !== '0 || key_applied !== 1'b0 || load_err !== 1'b0 || locked_out !== 1'b0) begin
         errors++; $display("FAIL rst_mid_outs got=%h/%b%b%b exp=0/000", key_out, key_applied, load_err, locked_out);
      end
      key = $urandom;
      pulse_load(1'b0);
      send_bits(make_frame(key, ref_cksum(key)), FRAME_BITS, 0);
      wait_idle(n);
      checks++; if (key_out !== key || key_applied !== 1'b1) begin errors++; $display("FAIL rst_reload got=%h/%b exp=%h/1", key_out, key_applied, key); end
   endtask

   task automatic test_random();
      int n, pre;
      logic [31:0] key, exp_key;
      bit good;
      for (int it = 0; it < 16; it++) begin
         if (m_locked) do_reset();
         key  = $urandom;
         good = (CK_ON == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         pulse_load(1'b0);
         if ($urandom_range(0, 3) == 0) begin
            pre = $urandom_range(1, FRAME_BITS - 1);
            send_bits({8'($urandom), 32'($urandom)}, pre, 1);
            pulse_load(1'($urandom_range(0, 1)));
         end
         send_bits(make_frame(key, good ? ref_cksum(key) : ref_cksum(key) ^ 8'($urandom_range(1, 255))),
                   FRAME_BITS, 2);
         if (good) m_fails = 0; else m_fails++;
         m_locked = (m_fails >= MAX_FAIL);
         exp_q.push_back(good ? key : '0);
         wait_idle(n);
         exp_key = exp_q.pop_front();
         checks++; if (n >= WAIT_MAX) begin errors++; $display("FAIL rand_%0d_timeout got=%0d exp<%0d cycles", it, n, WAIT_MAX); end
         checks++; if (key_out !== exp_key) begin errors++; $display("FAIL rand_%0d_key got=%h exp=%h", it, key_out, exp_key); end
         checks++; if (key_applied !== good || load_err !== !good || locked_out !== m_locked) begin
            errors++; $display("FAIL rand_%0d_flags got=%b%b%b exp=%b%b%b", it, key_applied, load_err, locked_out, good, !good, m_locked);
         end
      end
   endtask

   initial begin
      test_reset();
      test_good_load();
`ifdef KEY_LOADER_CHECKSUM_EN
      test_bad_checksum();
      test_lockout();
      test_fail_clear();
`endif
      test_restart_gaps();
      test_rst_mid_shift();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
